osd_cmd_sequencer: RTL and testbench
====================================

OSD_CMD_SEQUENCER -- requirements
Module: osd_cmd_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: number of clk_bus cycles each word stays on osd_command (legal 1..15).
REQ-002 SHALL have parameter SEP_WORD, default 16'hFF00: separator word, an opcode the overlay ignores.
REQ-003 SHALL use a single clock; reset is asynchronous and active-low.
REQ-004 clk_bus  in  1  system clock; the only clock.
REQ-005 areset_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  sequencer idle and able to accept.
REQ-008 req_op  in  3  0=OVERLAY_EN, 1=POPUP_EN, 2=PUTCHAR, 3=FILL, 4=FONT_RESET, 5=FONT_BYTE, 6/7=reserved.
REQ-009 req_x / req_y  in  5 each  cell column / row.
REQ-010 req_char  in  8  character code, or font byte for FONT_BYTE.
REQ-011 req_attr  in  8  attribute byte.
REQ-012 req_flag  in  1  enable value for OVERLAY_EN and POPUP_EN.
REQ-013 req_len  in  10  FILL cell count; 0 means 1024.
REQ-014 osd_command  out  16  command word to the overlay.
REQ-015 busy  out  1  sequence in progress; equals ~req_ready.

Function
REQ-016 SHALL accept a request on a cycle with req_valid=1 and req_ready=1, latch all req_* fields, and deassert req_ready on the next cycle.
REQ-017 SHALL drive the first word of the sequence on osd_command in the cycle after acceptance.
REQ-018 SHALL hold each word for exactly HOLD_CYCLES cycles before driving the next word.
REQ-019 SHALL reassert req_ready in the cycle after the last word's hold period ends.
REQ-020 SHALL leave osd_command at the last word while idle; it SHALL never return to a default value.
REQ-021 SHALL emit the following word sequences per opcode:
- OVERLAY_EN: {8'h01, 7'b0, flag}.
- POPUP_EN: {8'h02, 7'b0, flag}.
- PUTCHAR: {8'h10, 3'b0, x}, {8'h11, 3'b0, y}, {8'h12, char}, {8'h13, attr}.
- FONT_RESET: {8'h20, 8'h01}.
- FONT_BYTE: {8'h21, char}.
REQ-022 FILL SHALL emit the PUTCHAR 4-word group once per cell, for len cells, starting at (x,y).
REQ-023 FILL cursor SHALL advance after each cell: x+1; when x wraps 31->0, y+1; y wraps 31->0; all arithmetic is 5-bit modulo.
REQ-024 Separator rule: if the next word equals the word currently on osd_command, SHALL first drive SEP_WORD for HOLD_CYCLES, then the word.
- The check applies to the first word of a new request as well.
REQ-025 SHALL never emit two identical consecutive words, because the overlay acts only on a change of osd_command.
REQ-026 Reserved opcodes SHALL be accepted and SHALL complete in 1 cycle with no word emitted (req_ready low for exactly one cycle).
REQ-027 FSM states: IDLE, SEP, W_CMD (single-word ops), W_X, W_Y, W_CHAR, W_ATTR.
- IDLE->SEP or first word state on accept.
- W_X->W_Y->W_CHAR->W_ATTR.
- W_ATTR->W_X while FILL cells remain, else IDLE.
- W_CMD->IDLE.
- SEP->the pending word state.
REQ-028 SHALL use a hold counter of 4 bits that reloads on every word change.
REQ-029 SHALL use a remaining-cell counter of 11 bits so that len=0 yields 1024 cells.
REQ-030 SHALL ignore req_* fields while busy; changing inputs mid-sequence SHALL have no effect.

Reset
REQ-031 On areset_n low, regardless of clock and mid-sequence, SHALL immediately force:
- state=IDLE, osd_command=16'h0000, req_ready=1, busy=0.
- hold and cell counters and latched fields = 0.
REQ-032 After reset deassertion SHALL accept a request on the first clk_bus edge with req_valid=1.
REQ-033 A sequence interrupted by reset SHALL NOT resume.

Verification
REQ-034 PUTCHAR x=3, y=5, char=8'h41, attr=8'h70, HOLD_CYCLES=4 -> words 16'h1003, 16'h1105, 16'h1241, 16'h1370, each 4 cycles; req_ready returns 17 cycles after accept.
REQ-035 Two FONT_BYTE requests, both with char=8'hAA, back-to-back -> 16'h21AA, then 16'hFF00, then 16'h21AA; no repeated consecutive word.
REQ-036 FILL x=30, y=31, len=3, char=8'h20, attr=8'h07 -> cells (30,31), (31,31), (0,0); 12 words total, no separators.
REQ-037 FILL with len=0 -> exactly 4096 words emitted; busy stays high for 4096*HOLD_CYCLES cycles.
REQ-038 areset_n pulsed low during the W_CHAR state of a FILL -> osd_command=16'h0000 and req_ready=1 asynchronously; a following OVERLAY_EN flag=1 emits 16'h0101 with no separator.
REQ-039 Reserved opcode 6 -> no change on osd_command; req_ready low for exactly 1 cycle.

Source files
------------

// File: rtl/osd_cmd_sequencer.sv
// Turns one overlay request into a timed sequence of 16-bit command words, each held for HOLD_CYCLES.
// A separator word is inserted whenever the next word would repeat the word already on the bus.
module osd_cmd_sequencer #(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] SEP_WORD    = 16'hFF00
) (
  input  logic        clk_bus,
  input  logic        areset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_x,
  input  logic [4:0]  req_y,
  input  logic [7:0]  req_char,
  input  logic [7:0]  req_attr,
  input  logic        req_flag,
  input  logic [9:0]  req_len,
  output logic [15:0] osd_command,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SEP, W_CMD, W_X, W_Y, W_CHAR, W_ATTR} state_t;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES);

  state_t      state_q, state_d;
  state_t      pend_q, pend_d;
  logic [15:0] cmd_q, cmd_d;
  logic [3:0]  hold_q, hold_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;
  logic        flag_q, flag_d;
  logic [10:0] cells_q, cells_d;

  logic        go;
  state_t      tgt;
  logic [15:0] tgt_w;
  logic [4:0]  nx, ny;

  function automatic logic [15:0] word_of(input state_t s, input logic [2:0] op,
                                          input logic [4:0] x, input logic [4:0] y,
                                          input logic [7:0] ch, input logic [7:0] at,
                                          input logic fl);
    logic [15:0] w;
    w = SEP_WORD;
    case (s)
      W_X:    w = {8'h10, 3'b000, x};
      W_Y:    w = {8'h11, 3'b000, y};
      W_CHAR: w = {8'h12, ch};
      W_ATTR: w = {8'h13, at};
      W_CMD: begin
        case (op)
          3'd0:    w = {8'h01, 7'd0, fl};
          3'd1:    w = {8'h02, 7'd0, fl};
          3'd4:    w = 16'h2001;
          3'd5:    w = {8'h21, ch};
          default: w = SEP_WORD;
        endcase
      end
      default: w = SEP_WORD;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cmd_d   = cmd_q;
    hold_d  = hold_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    char_d  = char_q;
    attr_d  = attr_q;
    flag_d  = flag_q;
    cells_d = cells_q;
    go      = 1'b0;
    tgt     = IDLE;
    tgt_w   = 16'h0000;
    nx      = x_q + 5'd1;
    ny      = (x_q == 5'd31) ? y_q + 5'd1 : y_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          x_d     = req_x;
          y_d     = req_y;
          char_d  = req_char;
          attr_d  = req_attr;
          flag_d  = req_flag;
          cells_d = (req_op == 3'd3) ? ((req_len == 10'd0) ? 11'd1024 : {1'b0, req_len}) : 11'd1;
          // Reserved opcodes spend one busy cycle in W_CMD without touching the bus.
          if (req_op inside {3'd6, 3'd7}) begin
            state_d = W_CMD;
            hold_d  = 4'd1;
          end else begin
            go    = 1'b1;
            tgt   = (req_op == 3'd2 || req_op == 3'd3) ? W_X : W_CMD;
            tgt_w = word_of(tgt, req_op, req_x, req_y, req_char, req_attr, req_flag);
          end
        end
      end
      default: begin
        if (hold_q > 4'd1) begin
          hold_d = hold_q - 4'd1;
        end else begin
          case (state_q)
            SEP: begin
              state_d = pend_q;
              cmd_d   = word_of(pend_q, op_q, x_q, y_q, char_q, attr_q, flag_q);
              hold_d  = HOLD_LD;
            end
            W_X: begin
              go    = 1'b1;
              tgt   = W_Y;
              tgt_w = word_of(W_Y, op_q, x_q, y_q, char_q, attr_q, flag_q);
            end
            W_Y: begin
              go    = 1'b1;
              tgt   = W_CHAR;
              tgt_w = word_of(W_CHAR, op_q, x_q, y_q, char_q, attr_q, flag_q);
            end
            W_CHAR: begin
              go    = 1'b1;
              tgt   = W_ATTR;
              tgt_w = word_of(W_ATTR, op_q, x_q, y_q, char_q, attr_q, flag_q);
            end
            W_ATTR: begin
              cells_d = cells_q - 11'd1;
              if (cells_q > 11'd1) begin
                x_d   = nx;
                y_d   = ny;
                go    = 1'b1;
                tgt   = W_X;
                tgt_w = word_of(W_X, op_q, nx, ny, char_q, attr_q, flag_q);
              end else begin
                state_d = IDLE;
                hold_d  = 4'd0;
              end
            end
            default: begin
              state_d = IDLE;
              hold_d  = 4'd0;
            end
          endcase
        end
      end
    endcase

    // A repeated word would be invisible to the overlay, so park on the separator first.
    if (go) begin
      hold_d = HOLD_LD;
      if (tgt_w == cmd_q) begin
        state_d = SEP;
        pend_d  = tgt;
        cmd_d   = SEP_WORD;
      end else begin
        state_d = tgt;
        cmd_d   = tgt_w;
      end
    end
  end

  always_ff @(posedge clk_bus or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      pend_q  <= IDLE;
      cmd_q   <= 16'h0000;
      hold_q  <= 4'd0;
      op_q    <= 3'd0;
      x_q     <= 5'd0;
      y_q     <= 5'd0;
      char_q  <= 8'd0;
      attr_q  <= 8'd0;
      flag_q  <= 1'b0;
      cells_q <= 11'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      char_q  <= char_d;
      attr_q  <= attr_d;
      flag_q  <= flag_d;
      cells_q <= cells_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = ~req_ready;
  assign osd_command = cmd_q;

endmodule

// File: tb/tb_osd_cmd_sequencer.sv
// Directed bench for osd_cmd_sequencer: traces each request's word sequence, hold lengths and busy time.
// Expected words are hand-written per request; the len=0 fill uses a small cursor model.
module tb_osd_cmd_sequencer;

  logic        clk_bus = 1'b0;
  logic        areset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_x, req_y;
  logic [7:0]  req_char, req_attr;
  logic        req_flag;
  logic [9:0]  req_len;
  logic [15:0] osd_command;
  logic        busy;

  always #5 clk_bus = ~clk_bus;

  osd_cmd_sequencer #(.HOLD_CYCLES(4), .SEP_WORD(16'hFF00)) dut (
    .clk_bus(clk_bus), .areset_n(areset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .req_char(req_char), .req_attr(req_attr), .req_flag(req_flag), .req_len(req_len),
    .osd_command(osd_command), .busy(busy)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] wq[$];
  int          rq[$];
  int          bcyc;
  logic [15:0] pre_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk_bus);
    while (!req_ready && w < 200) begin
      @(negedge clk_bus);
      w++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] x, input logic [4:0] y,
                       input logic [7:0] ch, input logic [7:0] at, input logic fl,
                       input logic [9:0] len);
    req_op = op; req_x = x; req_y = y; req_char = ch; req_attr = at;
    req_flag = fl; req_len = len; req_valid = 1'b1;
    pre_w = osd_command;
    @(posedge clk_bus);
    #1;
    // Inputs are scrambled once accepted: a busy sequencer must not notice.
    req_valid = 1'b0;
    req_op = 3'($urandom); req_x = 5'($urandom); req_y = 5'($urandom);
    req_char = 8'($urandom); req_attr = 8'($urandom); req_flag = 1'($urandom);
    req_len = 10'($urandom);
  endtask

  task automatic do_req(input logic [2:0] op, input logic [4:0] x, input logic [4:0] y,
                        input logic [7:0] ch, input logic [7:0] at, input logic fl,
                        input logic [9:0] len, input int limit);
    logic [15:0] last;
    wait_ready();
    drive(op, x, y, ch, at, fl, len);
    wq.delete();
    rq.delete();
    bcyc = 0;
    last = pre_w;
    do begin
      @(negedge clk_bus);
      if (busy) begin
        bcyc++;
        if (osd_command != last) begin
          wq.push_back(osd_command);
          rq.push_back(1);
          last = osd_command;
        end else if (rq.size() > 0) begin
          rq[rq.size()-1] = rq[rq.size()-1] + 1;
        end
      end
    end while (busy && bcyc < limit);
    chk("seq_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_seq(input string tag, input logic [15:0] ex[$], input int cyc);
    chk({tag, "_nwords"}, wq.size(), ex.size());
    for (int i = 0; i < ex.size(); i++) begin
      if (i < wq.size()) begin
        chk($sformatf("%s_w%0d", tag, i), {16'd0, wq[i]}, {16'd0, ex[i]});
        chk($sformatf("%s_hold%0d", tag, i), rq[i], 4);
      end
    end
    chk({tag, "_busy_cycles"}, bcyc, cyc);
  endtask

  initial begin
    logic [15:0] ex[$];
    logic [15:0] mw;
    logic [4:0]  cx, cy;
    int          errs, w;

    areset_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_x = 5'd0; req_y = 5'd0;
    req_char = 8'd0; req_attr = 8'd0; req_flag = 1'b0; req_len = 10'd0;
    #3;
    chk("rst_cmd", {16'd0, osd_command}, 32'h0000);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #9 areset_n = 1'b1;

    // PUTCHAR (3,5) 'A' attr 70
    do_req(3'd2, 5'd3, 5'd5, 8'h41, 8'h70, 1'b0, 10'd0, 100);
    ex = '{16'h1003, 16'h1105, 16'h1241, 16'h1370};
    check_seq("putchar", ex, 16);

    do_req(3'd1, 5'd0, 5'd0, 8'h00, 8'h00, 1'b0, 10'd0, 100);
    ex = '{16'h0200};
    check_seq("popup", ex, 4);

    do_req(3'd4, 5'd0, 5'd0, 8'h00, 8'h00, 1'b0, 10'd0, 100);
    ex = '{16'h2001};
    check_seq("font_reset", ex, 4);

    do_req(3'd5, 5'd0, 5'd0, 8'hAA, 8'h00, 1'b0, 10'd0, 100);
    ex = '{16'h21AA};
    check_seq("fbyte1", ex, 4);

    do_req(3'd5, 5'd0, 5'd0, 8'hAA, 8'h00, 1'b0, 10'd0, 100);
    ex = '{16'hFF00, 16'h21AA};
    check_seq("fbyte2", ex, 8);

    // FILL wrapping through (31,31) -> (0,0)
    do_req(3'd3, 5'd30, 5'd31, 8'h20, 8'h07, 1'b0, 10'd3, 200);
    ex = '{16'h101E, 16'h111F, 16'h1220, 16'h1307,
           16'h101F, 16'h111F, 16'h1220, 16'h1307,
           16'h1000, 16'h1100, 16'h1220, 16'h1307};
    check_seq("fill3", ex, 48);

    do_req(3'd6, 5'd1, 5'd2, 8'h33, 8'h44, 1'b1, 10'd9, 100);
    chk("rsvd_nwords", wq.size(), 0);
    chk("rsvd_busy_cycles", bcyc, 1);
    chk("rsvd_cmd", {16'd0, osd_command}, 32'h1307);

    // FILL len=0: 1024 cells starting at (7,2)
    do_req(3'd3, 5'd7, 5'd2, 8'h55, 8'h66, 1'b0, 10'd0, 20000);
    chk("fill0_nwords", wq.size(), 4096);
    chk("fill0_busy_cycles", bcyc, 16384);
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      cx = 5'(7 + i);
      cy = 5'(2 + (7 + i) / 32);
      for (int k = 0; k < 4; k++) begin
        case (k)
          0:       mw = {8'h10, 3'b000, cx};
          1:       mw = {8'h11, 3'b000, cy};
          2:       mw = 16'h1255;
          default: mw = 16'h1366;
        endcase
        if (4*i + k >= wq.size()) errs++;
        else if (wq[4*i+k] != mw || rq[4*i+k] != 4) errs++;
      end
    end
    chk("fill0_word_errors", errs, 0);

    // Reset while a FILL sits in W_CHAR
    wait_ready();
    drive(3'd3, 5'd0, 5'd0, 8'h33, 8'h44, 1'b0, 10'd5);
    w = 0;
    while (osd_command != 16'h1233 && w < 50) begin
      @(negedge clk_bus);
      w++;
    end
    chk("reach_wchar", {16'd0, osd_command}, 32'h1233);
    #2 areset_n = 1'b0;
    #1;
    chk("arst_cmd", {16'd0, osd_command}, 32'h0000);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_bus);
    areset_n = 1'b1;
    repeat (3) @(negedge clk_bus);
    chk("no_resume_cmd", {16'd0, osd_command}, 32'h0000);
    chk("no_resume_busy", {31'd0, busy}, 32'd0);

    do_req(3'd0, 5'd0, 5'd0, 8'h00, 8'h00, 1'b1, 10'd0, 100);
    ex = '{16'h0101};
    check_seq("ovl_after_rst", ex, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
